// File: rtl/stream_mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer: channel-index width
// derivation and the packet-lock FSM state type.
package stream_mux_pkg;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    ARB,
    LOCK
  } state_t;

endpackage

// File: rtl/stream_mux_rr_if.sv
// Stream bundle for stream_mux_rr: N_CH input channels and one output stream.
// STREAM_MUX_LAST_EN adds per-channel in_last and out_last.
interface stream_mux_rr_if
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
);
  localparam int SEL_W = sel_w(N_CH);

  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [SEL_W-1:0]      out_sel;
`ifdef STREAM_MUX_LAST_EN
  logic [N_CH-1:0]       in_last;
  logic                  out_last;
`endif

  // The multiplexer itself.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sel
`ifdef STREAM_MUX_LAST_EN
    , input in_last, output out_last
`endif
  );

  // Producers and consumer around the multiplexer.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sel
`ifdef STREAM_MUX_LAST_EN
    , output in_last, input out_last
`endif
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin priority selector: grants the first requesting
// channel at or after ptr, wrapping modulo N_CH.
module rr_pick
  import stream_mux_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0]         req,
  input  logic [sel_w(N_CH)-1:0]  ptr,
  output logic [sel_w(N_CH)-1:0]  grant,
  output logic                    any
);
  localparam int SEL_W = sel_w(N_CH);

  // One extra bit so ptr + offset never overflows before the modulo fold.
  logic [SEL_W:0] idx;

  // NOTE: every output gets a default first so no path through the loop infers a latch.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    // Walk offsets from farthest to nearest so the nearest request wins last.
    for (int i = N_CH - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (SEL_W + 1)'(i);
      if (idx >= (SEL_W + 1)'(N_CH)) idx = idx - (SEL_W + 1)'(N_CH);
      if (req[idx[SEL_W-1:0]]) begin
        grant = idx[SEL_W-1:0];
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel round-robin stream multiplexer with a single registered output stage.
// Define STREAM_MUX_LAST_EN to hold the grant on one channel until its in_last beat.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  stream_mux_rr_if.slave  bus
);
  localparam int SEL_W = sel_w(N_CH);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] ptr_next;
  logic [N_CH-1:0]  req;
  logic [WIDTH-1:0] grant_data;
  logic             any;
  logic             load_en;
  logic             fire;

`ifdef STREAM_MUX_LAST_EN
  state_t state;
  logic   grant_last;

  // While locked, out_sel still names the owning channel, so it doubles as the lock.
  always_comb begin
    req = bus.in_valid;
    if (state == LOCK) req = bus.in_valid & (N_CH'(1) << bus.out_sel);
  end
`else
  assign req = bus.in_valid;
`endif

  rr_pick #(.N_CH(N_CH)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (grant),
    .any   (any)
  );

  assign load_en     = !bus.out_valid || bus.out_ready;
  assign fire        = load_en && any && !rst;
  assign bus.in_ready = fire ? (N_CH'(1) << grant) : '0;
  assign ptr_next    = (grant == SEL_W'(N_CH - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    grant_data = '0;
`ifdef STREAM_MUX_LAST_EN
    grant_last = 1'b0;
`endif
    for (int k = 0; k < N_CH; k++) begin
      if (grant == SEL_W'(k)) begin
        grant_data = bus.in_data[k*WIDTH +: WIDTH];
`ifdef STREAM_MUX_LAST_EN
        grant_last = bus.in_last[k];
`endif
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sel   <= '0;
      ptr           <= '0;
`ifdef STREAM_MUX_LAST_EN
      bus.out_last  <= 1'b0;
      state         <= ARB;
`endif
    end else if (load_en) begin
      if (any) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= grant_data;
        bus.out_sel   <= grant;
        ptr           <= ptr_next;
`ifdef STREAM_MUX_LAST_EN
        bus.out_last  <= grant_last;
        // A non-final beat (re)locks onto its channel; a final beat returns to arbitration.
        state         <= grant_last ? ARB : LOCK;
`endif
      end else begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: directed scenarios plus randomized traffic
// checked against a queue-free behavioural model of the arbitration rules.
module tb_stream_mux_rr;
  import stream_mux_pkg::*;

  localparam int N_CH  = 4;
  localparam int WIDTH = 8;
  localparam int SEL_W = sel_w(N_CH);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  stream_mux_rr_if #(.N_CH(N_CH), .WIDTH(WIDTH)) bus ();

  stream_mux_rr #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural model state: what the output register and arbiter should hold.
  int         m_ptr   = 0;
  bit         m_valid = 0;
  logic [7:0] m_data  = '0;
  int         m_sel   = 0;
  bit         m_last  = 0;
  bit         m_lock  = 0;

  function automatic logic [7:0] ch_data(input int k);
    logic [N_CH*WIDTH-1:0] d;
    d = bus.in_data;
    return d[k*WIDTH +: WIDTH];
  endfunction

  // One clock of traffic: inputs are already driven after a falling edge.
  task automatic step(input string tag);
    bit              load, found, last;
    int              g;
    logic [N_CH-1:0] exp_ready;
    logic [7:0]      d;
    load  = !m_valid || bus.out_ready;
    found = 0;
    g     = 0;
    last  = 0;
    if (m_lock) begin
      if (bus.in_valid[m_sel]) begin found = 1; g = m_sel; end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        int ch;
        ch = (m_ptr + i) % N_CH;
        if (!found && bus.in_valid[ch]) begin found = 1; g = ch; end
      end
    end
    exp_ready = (load && found && !rst) ? (N_CH'(1) << g) : '0;
    d = ch_data(g);
`ifdef STREAM_MUX_LAST_EN
    last = bus.in_last[g];
`endif
    #1;
    checks++;
    if (bus.in_ready !== exp_ready) begin
      errors++;
      $display("FAIL %s in_ready: got %b expected %b", tag, bus.in_ready, exp_ready);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0; m_lock = 0; m_last = 0;
    end else if (load) begin
      if (found) begin
        m_valid = 1; m_data = d; m_sel = g; m_ptr = (g + 1) % N_CH;
        m_last = last;
`ifdef STREAM_MUX_LAST_EN
        m_lock = !last;
`endif
      end else begin
        m_valid = 0;
      end
    end
    checks++;
    if (bus.out_valid !== m_valid || bus.out_data !== m_data || bus.out_sel !== SEL_W'(m_sel)) begin
      errors++;
      $display("FAIL %s out: got v=%b d=%h s=%0d expected v=%b d=%h s=%0d", tag,
               bus.out_valid, bus.out_data, bus.out_sel, m_valid, m_data, m_sel);
    end
`ifdef STREAM_MUX_LAST_EN
    checks++;
    if (bus.out_last !== m_last) begin
      errors++;
      $display("FAIL %s out_last: got %b expected %b", tag, bus.out_last, m_last);
    end
`endif
    @(negedge clk);
  endtask

  task automatic drive_all(input logic [N_CH-1:0] valid);
    bus.in_valid = valid;
    for (int k = 0; k < N_CH; k++) bus.in_data[k*WIDTH +: WIDTH] = 8'(8'hA0 + k);
  endtask

  task automatic test_reset();
    drive_all('1);
    bus.out_ready = 1'b1;
    rst = 1'b1;
    step("reset_0");
    step("reset_1");
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_sel !== '0 || bus.in_ready !== '0) begin
      errors++;
      $display("FAIL reset_values: got v=%b d=%h s=%0d r=%b expected v=0 d=00 s=0 r=0000",
               bus.out_valid, bus.out_data, bus.out_sel, bus.in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    int exp_sel[5] = '{0, 1, 2, 3, 0};
    drive_all('1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step("rr");
      checks++;
      if (bus.out_sel !== SEL_W'(exp_sel[i]) || bus.out_data !== 8'(8'hA0 + exp_sel[i]) || !bus.out_valid) begin
        errors++;
        $display("FAIL rr_beat%0d: got s=%0d d=%h v=%b expected s=%0d d=%h v=1", i,
                 bus.out_sel, bus.out_data, bus.out_valid, exp_sel[i], 8'(8'hA0 + exp_sel[i]));
      end
    end
  endtask

  task automatic test_backpressure();
    rst = 1'b1; step("bp_rst"); rst = 1'b0;
    drive_all('1);
    bus.out_ready = 1'b1;
    step("bp_a0");
    step("bp_a1");
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("bp_hold");
      checks++;
      if (bus.out_data !== 8'hA1 || bus.out_valid !== 1'b1 || bus.in_ready !== '0) begin
        errors++;
        $display("FAIL bp_hold%0d: got d=%h v=%b r=%b expected d=a1 v=1 r=0000", i,
                 bus.out_data, bus.out_valid, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    step("bp_release");
    checks++;
    if (bus.out_data !== 8'hA2 || bus.out_sel !== SEL_W'(2)) begin
      errors++;
      $display("FAIL bp_release: got d=%h s=%0d expected d=a2 s=2", bus.out_data, bus.out_sel);
    end
  endtask

  task automatic test_sparse();
    rst = 1'b1; step("sp_rst"); rst = 1'b0;
    bus.out_ready = 1'b1;
    drive_all(4'b0100);
    step("sp_first");
    bus.in_data[2*WIDTH +: WIDTH] = 8'h55;
    step("sp_wrap");
    checks++;
    if (bus.out_sel !== SEL_W'(2) || bus.out_data !== 8'h55 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL sp_wrap: got s=%0d d=%h v=%b expected s=2 d=55 v=1",
               bus.out_sel, bus.out_data, bus.out_valid);
    end
    bus.in_valid = '0;
    step("sp_idle");
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h55) begin
      errors++;
      $display("FAIL sp_idle: got v=%b d=%h expected v=0 d=55", bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_reset_mid();
    drive_all('1);
    bus.out_ready = 1'b0;
    step("rm_a");
    step("rm_b");
    rst = 1'b1;
    step("rm_rst");
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_drop: got v=%b expected v=0", bus.out_valid);
    end
    rst = 1'b0;
    step("rm_restart");
    checks++;
    if (bus.out_sel !== '0 || bus.out_data !== 8'hA0) begin
      errors++;
      $display("FAIL rm_restart: got s=%0d d=%h expected s=0 d=a0", bus.out_sel, bus.out_data);
    end
  endtask

`ifdef STREAM_MUX_LAST_EN
  task automatic test_packet();
    int exp_sel[5] = '{0, 1, 1, 1, 2};
    rst = 1'b1; step("pk_rst"); rst = 1'b0;
    drive_all(4'b0111);
    bus.out_ready = 1'b1;
    bus.in_last = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      bus.in_last[1] = (i == 3);
      step("pk");
      checks++;
      if (bus.out_sel !== SEL_W'(exp_sel[i]) || bus.out_last !== (i != 1 && i != 2)) begin
        errors++;
        $display("FAIL pk_beat%0d: got s=%0d l=%b expected s=%0d l=%b", i,
                 bus.out_sel, bus.out_last, exp_sel[i], (i != 1 && i != 2));
      end
    end
    bus.in_last = '0;
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst           = ($urandom_range(0, 49) == 0);
      bus.in_valid  = N_CH'($urandom);
      bus.in_data   = (N_CH*WIDTH)'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
`ifdef STREAM_MUX_LAST_EN
      bus.in_last   = N_CH'($urandom);
`endif
      step("rand");
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef STREAM_MUX_LAST_EN
    bus.in_last   = '1;
`endif
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_backpressure();
    test_sparse();
    test_reset_mid();
`ifdef STREAM_MUX_LAST_EN
    test_packet();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
